// File: rtl/pic_pkg.sv
// pic_pkg: init-state encoding, OCW2 command codes and the rotating priority search shared by
// the controller and its priority resolver.
package pic_pkg;
  typedef enum logic [1:0] {S_READY, S_ICW2, S_ICW3, S_ICW4} init_state_e;
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_S_EOI        = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;
  // Scans from lowest to highest priority so the last hit is the highest-priority request.
  function automatic logic [3:0] rotating_priority(input logic [7:0] req, input logic [2:0] lowest);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = lowest + 3'(i) + 3'd1;
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
endpackage

// File: rtl/pic_8259_priority_resolver.sv
// pic_priority_resolver: picks the highest-priority unmasked request that outranks every
// level currently in service.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] irr_i,
  input  logic [7:0] imr_i,
  input  logic [7:0] isr_i,
  input  logic [2:0] lowest_i,
  output logic       valid_o,
  output logic [2:0] level_o
);
  logic [3:0] req_w, isr_w;
  logic [2:0] req_rank, isr_rank;
  assign req_w    = rotating_priority(irr_i & ~imr_i, lowest_i);
  assign isr_w    = rotating_priority(isr_i, lowest_i);
  assign req_rank = req_w[2:0] - lowest_i - 3'd1;
  assign isr_rank = isr_w[2:0] - lowest_i - 3'd1;
  assign valid_o  = req_w[3] && (!isr_w[3] || req_rank < isr_rank);
  assign level_o  = req_w[2:0];
endmodule

// File: rtl/pic_8259.sv
// pic_8259: single 8259A-compatible interrupt controller, io slave at 020h-021h, presenting a
// vector to the CPU with a do/done handshake.
module pic_8259
  import pic_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE_RESET = 8'h08,
  parameter logic [7:0] IMR_RESET         = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_address,
  input  logic       io_read,
  output logic [7:0] io_readdata,
  input  logic       io_write,
  input  logic [7:0] io_writedata,
  input  logic [7:0] interrupt_input,
  output logic       interrupt_do,
  output logic [7:0] interrupt_vector,
  input  logic       interrupt_done
);
  init_state_e state_q, state_d;
  logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, in_q, vec_q, vec_d, rd_q, rd_d;
  logic [4:0] base_q, base_d;
  logic [2:0] lowest_q, lowest_d;
  logic ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d, aeoi_q, aeoi_d;
  logic rot_q, rot_d, rsel_q, rsel_d, poll_q, poll_d, do_q, do_d;
  logic win_v, eoi_v, icw1, ready_wr, ocw2, ocw3, poll_rd, pend, ack;
  logic [2:0] win_lvl, eoi_lvl, ack_lvl;
  logic [7:0] ack_mask, eoi_mask, spec_mask;
  pic_priority_resolver u_win (
    .irr_i(irr_q), .imr_i(imr_q), .isr_i(isr_q), .lowest_i(lowest_q),
    .valid_o(win_v), .level_o(win_lvl)
  );
  // Highest in-service level, the target of a non-specific EOI.
  pic_priority_resolver u_eoi (
    .irr_i(isr_q), .imr_i(8'h00), .isr_i(8'h00), .lowest_i(lowest_q),
    .valid_o(eoi_v), .level_o(eoi_lvl)
  );
  assign icw1      = io_write && !io_address && io_writedata[4];
  assign ready_wr  = io_write && state_q == S_READY;
  assign ocw2      = ready_wr && !io_address && io_writedata[4:3] == 2'b00;
  assign ocw3      = ready_wr && !io_address && io_writedata[4:3] == 2'b01;
  assign poll_rd   = io_read && !io_address && poll_q;
  assign pend      = do_q || win_v;
  // A poll read acknowledges exactly like interrupt_done; a presented vector takes precedence.
  assign ack       = (interrupt_done && do_q) || (poll_rd && pend);
  assign ack_lvl   = do_q ? vec_q[2:0] : win_lvl;
  assign ack_mask  = ack ? 8'd1 << ack_lvl : 8'd0;
  assign eoi_mask  = eoi_v ? 8'd1 << eoi_lvl : 8'd0;
  assign spec_mask = 8'd1 << io_writedata[2:0];
  always_comb begin
    irr_d    = ltim_q ? interrupt_input : (irr_q & ~ack_mask) | (interrupt_input & ~in_q);
    isr_d    = ack && !aeoi_q ? isr_q | ack_mask : isr_q;
    imr_d    = ready_wr && io_address ? io_writedata : imr_q;
    lowest_d = ack && aeoi_q && rot_q ? ack_lvl : lowest_q;
    rot_d    = rot_q;
    rsel_d   = ocw3 && io_writedata[1] ? io_writedata[0] : rsel_q;
    poll_d   = ocw3 && io_writedata[2] ? 1'b1 : poll_rd ? 1'b0 : poll_q;
    base_d   = base_q;
    aeoi_d   = aeoi_q;
    ltim_d   = ltim_q;
    sngl_d   = sngl_q;
    ic4_d    = ic4_q;
    state_d  = state_q;
    rd_d     = !io_read ? rd_q : io_address ? imr_q :
               poll_q ? {pend, 4'b0, pend ? ack_lvl : 3'd0} : rsel_q ? isr_q : irr_q;
    do_d     = icw1 ? 1'b0 : do_q ? !(interrupt_done || poll_rd) : win_v && !poll_q;
    vec_d    = !do_q && win_v ? {base_q, win_lvl} : vec_q;
    if (ocw2)
      case (io_writedata[7:5])
        OCW2_ROT_AEOI_CLR: rot_d = 1'b0;
        OCW2_NS_EOI:       isr_d = isr_d & ~eoi_mask;
        OCW2_NOP:          ;
        OCW2_S_EOI:        isr_d = isr_d & ~spec_mask;
        OCW2_ROT_AEOI_SET: rot_d = 1'b1;
        OCW2_ROT_NS_EOI: begin
          isr_d    = isr_d & ~eoi_mask;
          lowest_d = eoi_v ? eoi_lvl : lowest_q;
        end
        OCW2_SET_PRIO:     lowest_d = io_writedata[2:0];
        OCW2_ROT_S_EOI: begin
          isr_d    = isr_d & ~spec_mask;
          lowest_d = io_writedata[2:0];
        end
      endcase
    if (io_write && io_address && state_q != S_READY) begin
      base_d  = state_q == S_ICW2 ? io_writedata[7:3] : base_q;
      aeoi_d  = state_q == S_ICW4 ? io_writedata[1] : aeoi_q;
      state_d = state_q == S_ICW2 && !sngl_q ? S_ICW3 :
                state_q != S_ICW4 && ic4_q ? S_ICW4 : S_READY;
    end
    if (icw1) begin
      ltim_d   = io_writedata[3];
      sngl_d   = io_writedata[1];
      ic4_d    = io_writedata[0];
      imr_d    = 8'h00;
      isr_d    = 8'h00;
      lowest_d = 3'd7;
      rsel_d   = 1'b0;
      aeoi_d   = 1'b0;
      state_d  = S_ICW2;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_READY;
      irr_q    <= 8'h00;
      isr_q    <= 8'h00;
      imr_q    <= IMR_RESET;
      in_q     <= 8'h00;
      vec_q    <= 8'h00;
      rd_q     <= 8'h00;
      base_q   <= VECTOR_BASE_RESET[7:3];
      lowest_q <= 3'd7;
      ltim_q   <= 1'b0;
      sngl_q   <= 1'b0;
      ic4_q    <= 1'b0;
      aeoi_q   <= 1'b0;
      rot_q    <= 1'b0;
      rsel_q   <= 1'b0;
      poll_q   <= 1'b0;
      do_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      imr_q    <= imr_d;
      in_q     <= interrupt_input;
      vec_q    <= vec_d;
      rd_q     <= rd_d;
      base_q   <= base_d;
      lowest_q <= lowest_d;
      ltim_q   <= ltim_d;
      sngl_q   <= sngl_d;
      ic4_q    <= ic4_d;
      aeoi_q   <= aeoi_d;
      rot_q    <= rot_d;
      rsel_q   <= rsel_d;
      poll_q   <= poll_d;
      do_q     <= do_d;
    end
  end
  assign io_readdata      = rd_q;
  assign interrupt_do     = do_q;
  assign interrupt_vector = vec_q;
endmodule
